// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - signal bundle between the front-panel register and the display scan controller
//
// Purpose: groups the display request (value, dp, digit_en, blink, lz_blank)
// and the board pin drive (an_n, seg_n, dp_n) plus the frame_tick strobe.
//
// Signals:
//   value      16  hex digits, digit0 = value[3:0] (rightmost)
//   dp          4  decimal point request per digit
//   digit_en    4  per-digit enable, 0 = digit dark
//   blink       4  per-digit blink enable
//   lz_blank    1  leading-zero suppression enable
//   an_n        4  anode drive, active-low, an_n[i] selects digit i
//   seg_n       7  segments {a,b,c,d,e,f,g}, active-low
//   dp_n        1  decimal point, active-low
//   frame_tick  1  one-cycle pulse after each snapshot
//
// Modports:
//   master  the register side: drives the request, observes the pins
//   slave   the scan controller: consumes the request, drives the pins

interface seg7_scan_ctrl_if;

   logic [15:0] value;
   logic [3:0]  dp;
   logic [3:0]  digit_en;
   logic [3:0]  blink;
   logic        lz_blank;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic        frame_tick;

   modport master (
      output value,
      output dp,
      output digit_en,
      output blink,
      output lz_blank,
      input  an_n,
      input  seg_n,
      input  dp_n,
      input  frame_tick
   );

   modport slave (
      input  value,
      input  dp,
      input  digit_en,
      input  blink,
      input  lz_blank,
      output an_n,
      output seg_n,
      output dp_n,
      output frame_tick
   );

endinterface

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - time-multiplexed scan controller for a 4-digit common-anode 7-segment display
//
// Purpose: snapshots the display request once per frame, then steps one digit
// per slot through a single hex_7seg decoder. Each slot starts with a guard
// interval with all anodes off so that ghosting between digits cannot occur.
//
// Ports (seg7_scan_ctrl):
//   clk        in   system clock
//   reset_in   in   asynchronous, active-high reset
//   bus        slave modport of seg7_scan_ctrl_if (request in, pin drive out)
//
// Ports (hex_7seg):
//   nibble     in   4-bit hex digit
//   seg_n      out  segments {a,b,c,d,e,f,g}, active-low
//
// Parameters:
//   PRESCALE      clk cycles per digit slot, must exceed BLANK_CYCLES
//   BLANK_CYCLES  guard cycles at the start of each slot, at least 1
//   BLINK_DIV     frames per blink half-period, at least 1

module hex_7seg (
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = 7'h7F;
      case (nibble)
         4'h0: seg_n = 7'b0000001;
         4'h1: seg_n = 7'b1001111;
         4'h2: seg_n = 7'b0010010;
         4'h3: seg_n = 7'b0000110;
         4'h4: seg_n = 7'b1001100;
         4'h5: seg_n = 7'b0100100;
         4'h6: seg_n = 7'b0100000;
         4'h7: seg_n = 7'b0001111;
         4'h8: seg_n = 7'b0000000;
         4'h9: seg_n = 7'b0000100;
         4'hA: seg_n = 7'b0001000;
         4'hB: seg_n = 7'b1100000;
         4'hC: seg_n = 7'b0110001;
         4'hD: seg_n = 7'b1000010;
         4'hE: seg_n = 7'b0110000;
         4'hF: seg_n = 7'b0111000;
         default: seg_n = 7'h7F;
      endcase
   end

endmodule

module seg7_scan_ctrl #(
   parameter int PRESCALE     = 12500,
   parameter int BLANK_CYCLES = 64,
   parameter int BLINK_DIV    = 32
) (
   input  logic            clk,
   input  logic            reset_in,
   seg7_scan_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(PRESCALE);
   localparam int FC_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] CNT_ON   = CNT_W'(BLANK_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_DIV - 1);
   localparam logic [FC_W-1:0]  FC_ONE   = FC_W'(1);

   // ------------------------------------------------------------------
   // Slot / digit counters
   // ------------------------------------------------------------------
   logic [1:0]       digit;
   logic [CNT_W-1:0] cnt;
   logic             slot_last;
   logic             frame_start;
   logic             slot_on;

   assign slot_last   = (cnt == CNT_LAST);
   assign frame_start = (digit == 2'd0) && (cnt == '0);
   assign slot_on     = (cnt >= CNT_ON);

   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         digit <= 2'd0;
         cnt   <= '0;
      end else if (slot_last) begin
         cnt   <= '0;
         digit <= digit + 2'd1;
      end else begin
         cnt   <= cnt + CNT_ONE;
      end
   end

   // ------------------------------------------------------------------
   // Frame snapshot and blink phase
   // ------------------------------------------------------------------
   logic [15:0]     snap_value;
   logic [3:0]      snap_dp;
   logic [3:0]      snap_en;
   logic [3:0]      snap_blink;
   logic            snap_lz;
   logic [FC_W-1:0] frame_cnt;
   logic            blink_phase;

   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         snap_value  <= 16'h0000;
         snap_dp     <= 4'h0;
         snap_en     <= 4'h0;
         snap_blink  <= 4'h0;
         snap_lz     <= 1'b0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_start) begin
         snap_value <= bus.value;
         snap_dp    <= bus.dp;
         snap_en    <= bus.digit_en;
         snap_blink <= bus.blink;
         snap_lz    <= bus.lz_blank;
         // The phase toggles on the same edge as the capture, so the new
         // phase governs the frame that has just been snapshotted.
         if (frame_cnt == FC_LAST) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt   <= frame_cnt + FC_ONE;
         end
      end
   end

   // ------------------------------------------------------------------
   // Digit selection, visibility and decode
   // ------------------------------------------------------------------
   logic [3:0] nibble;
   logic [6:0] dec_seg_n;
   logic [3:0] nib_zero;
   logic [3:0] lz_sup;
   logic       shown;

   assign nibble = snap_value[{digit, 2'b00} +: 4];

   hex_7seg u_hex_7seg (
      .nibble (nibble),
      .seg_n  (dec_seg_n)
   );

   always_comb begin
      nib_zero[0] = (snap_value[3:0]   == 4'h0);
      nib_zero[1] = (snap_value[7:4]   == 4'h0);
      nib_zero[2] = (snap_value[11:8]  == 4'h0);
      nib_zero[3] = (snap_value[15:12] == 4'h0);
   end

   // A digit is suppressed only when it and every digit to its left are zero;
   // digit0 always shows so that a zero value still reads "0".
   always_comb begin
      lz_sup[0] = 1'b0;
      lz_sup[1] = snap_lz && nib_zero[3] && nib_zero[2] && nib_zero[1];
      lz_sup[2] = snap_lz && nib_zero[3] && nib_zero[2];
      lz_sup[3] = snap_lz && nib_zero[3];
   end

   // Enabled and not in the dark half of a blink.
   assign shown = snap_en[digit] && !(snap_blink[digit] && blink_phase);

   // ------------------------------------------------------------------
   // Next pin state and output registers
   // ------------------------------------------------------------------
   logic [3:0] an_next;
   logic [6:0] seg_next;
   logic       dp_next;
   logic [3:0] an_sel;

   assign an_sel = ~(4'b0001 << digit);

   always_comb begin
      an_next  = 4'hF;
      seg_next = 7'h7F;
      dp_next  = 1'b1;
      if (slot_on && shown) begin
         if (!lz_sup[digit]) begin
            an_next  = an_sel;
            seg_next = dec_seg_n;
            dp_next  = ~snap_dp[digit];
         end else if (snap_dp[digit]) begin
            // Suppressed zero still carries its decimal point.
            an_next  = an_sel;
            dp_next  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         bus.an_n       <= 4'hF;
         bus.seg_n      <= 7'h7F;
         bus.dp_n       <= 1'b1;
         bus.frame_tick <= 1'b0;
      end else begin
         bus.an_n       <= an_next;
         bus.seg_n      <= seg_next;
         bus.dp_n       <= dp_next;
         bus.frame_tick <= frame_start;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

   localparam int PS    = 8;
   localparam int BC    = 2;
   localparam int BD    = 2;
   localparam int FRAME = 4 * PS;

   localparam logic [6:0] SEG_TAB [0:15] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   logic clk;
   logic reset_in;

   seg7_scan_ctrl_if bus ();

   seg7_scan_ctrl #(
      .PRESCALE     (PS),
      .BLANK_CYCLES (BC),
      .BLINK_DIV    (BD)
   ) dut (
      .clk      (clk),
      .reset_in (reset_in),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors;
   int miscompares;
   int t;

   logic [15:0] s_value [0:31];
   logic [3:0]  s_dp    [0:31];
   logic [3:0]  s_en    [0:31];
   logic [3:0]  s_blink [0:31];
   logic        s_lz    [0:31];

   // Expected pins for cycle t, derived from frame/slot arithmetic and the
   // inputs the bench presented at each frame's capture cycle.
   task automatic model_check();
      logic [3:0]  e_an;
      logic [6:0]  e_seg;
      logic        e_dp;
      logic        e_ft;
      int          p;
      int          f;
      int          d;
      int          c;
      logic [1:0]  d2;
      logic [15:0] v;
      logic [3:0]  nib;
      bit          phase;
      bit          vis;
      bit          supp;
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      e_ft  = 1'b0;
      if (t > 0) begin
         p     = t - 1;
         f     = p / FRAME;
         d     = (p % FRAME) / PS;
         c     = p % PS;
         d2    = 2'(d);
         e_ft  = ((p % FRAME) == 0);
         v     = s_value[f[4:0]];
         nib   = 4'(v >> (4 * d));
         phase = (((f + 1) / BD) % 2) == 1;
         vis   = s_en[f[4:0]][d2] && !(s_blink[f[4:0]][d2] && phase);
         supp  = s_lz[f[4:0]] && (d != 0) && ((v >> (4 * d)) == 16'h0000);
         if (c >= BC && vis) begin
            if (!supp) begin
               e_an  = ~(4'b0001 << d2);
               e_seg = SEG_TAB[nib];
               e_dp  = ~s_dp[f[4:0]][d2];
            end else if (s_dp[f[4:0]][d2]) begin
               e_an  = ~(4'b0001 << d2);
               e_dp  = 1'b0;
            end
         end
      end
      vectors++;
      if (bus.an_n !== e_an || bus.seg_n !== e_seg || bus.dp_n !== e_dp || bus.frame_tick !== e_ft) begin
         miscompares++;
         $display("FAIL model t=%0d got an_n=%b seg_n=%b dp_n=%b frame_tick=%b exp an_n=%b seg_n=%b dp_n=%b frame_tick=%b",
                  t, bus.an_n, bus.seg_n, bus.dp_n, bus.frame_tick, e_an, e_seg, e_dp, e_ft);
      end
   endtask

   task automatic lit(input string name, input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
      vectors++;
      if (bus.an_n !== e_an || bus.seg_n !== e_seg || bus.dp_n !== e_dp) begin
         miscompares++;
         $display("FAIL %s t=%0d got an_n=%b seg_n=%b dp_n=%b exp an_n=%b seg_n=%b dp_n=%b",
                  name, t, bus.an_n, bus.seg_n, bus.dp_n, e_an, e_seg, e_dp);
      end
   endtask

   task automatic tick_chk(input string name, input logic e_ft);
      vectors++;
      if (bus.frame_tick !== e_ft) begin
         miscompares++;
         $display("FAIL %s t=%0d got frame_tick=%b exp %b", name, t, bus.frame_tick, e_ft);
      end
   endtask

   // One clock: record the frame request at capture cycles, advance, then
   // compare on the falling edge.
   task automatic tick();
      int f;
      @(posedge clk);
      if ((t % FRAME) == 0) begin
         f = t / FRAME;
         s_value[f[4:0]] = bus.value;
         s_dp[f[4:0]]    = bus.dp;
         s_en[f[4:0]]    = bus.digit_en;
         s_blink[f[4:0]] = bus.blink;
         s_lz[f[4:0]]    = bus.lz_blank;
      end
      t++;
      @(negedge clk);
      model_check();
   endtask

   task automatic run_to(input int k);
      for (int g = 0; g < 20000 && t < k; g++) tick();
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      t            = 0;
      reset_in     = 1'b1;
      bus.value    = 16'h1A2F;
      bus.dp       = 4'h0;
      bus.digit_en = 4'hF;
      bus.blink    = 4'h0;
      bus.lz_blank = 1'b0;
      #1;
      lit("reset_pins", 4'hF, 7'h7F, 1'b1);
      tick_chk("reset_tick", 1'b0);
      repeat (3) @(negedge clk);
      reset_in = 1'b0;
      t = 0;
      model_check();

      // Plain hex display.
      run_to(1);   tick_chk("tick_c1", 1'b1);
      run_to(2);   tick_chk("tick_c2", 1'b0);
                   lit("blank_c2", 4'hF, 7'h7F, 1'b1);
      run_to(3);   lit("d0_F_first", 4'b1110, 7'b0111000, 1'b1);
      run_to(8);   lit("d0_F_last", 4'b1110, 7'b0111000, 1'b1);
      run_to(9);   lit("guard_c9", 4'hF, 7'h7F, 1'b1);
      run_to(10);  lit("guard_c10", 4'hF, 7'h7F, 1'b1);
      run_to(11);  lit("d1_2", 4'b1101, 7'b0010010, 1'b1);
      run_to(19);  lit("d2_A", 4'b1011, 7'b0001000, 1'b1);
      run_to(27);  lit("d3_1", 4'b0111, 7'b1001111, 1'b1);
      run_to(33);  tick_chk("tick_c33", 1'b1);
      run_to(65);  tick_chk("tick_c65", 1'b1);

      // Leading-zero suppression.
      run_to(96);
      bus.value    = 16'h0050;
      bus.lz_blank = 1'b1;
      run_to(101); lit("lz_d0_0", 4'b1110, 7'b0000001, 1'b1);
      run_to(108); lit("lz_d1_5", 4'b1101, 7'b0100100, 1'b1);
      run_to(116); lit("lz_d2_dark", 4'hF, 7'h7F, 1'b1);
      run_to(124); lit("lz_d3_dark", 4'hF, 7'h7F, 1'b1);
      run_to(128);
      bus.dp = 4'b1000;
      run_to(148); lit("lz_d2_nodp", 4'hF, 7'h7F, 1'b1);
      run_to(156); lit("lz_d3_dp", 4'b0111, 7'h7F, 1'b0);

      // Mid-frame input change is held off until the next snapshot.
      run_to(160);
      bus.value    = 16'h1234;
      bus.dp       = 4'h0;
      bus.lz_blank = 1'b0;
      run_to(180);
      bus.value    = 16'hFFFF;
      run_to(181); lit("old_d2_2", 4'b1011, 7'b0010010, 1'b1);
      run_to(188); lit("old_d3_1", 4'b0111, 7'b1001111, 1'b1);
      run_to(195); lit("new_d0_F", 4'b1110, 7'b0111000, 1'b1);

      // All digits disabled: dark frame, ticks continue.
      run_to(224);
      bus.digit_en = 4'h0;
      run_to(225); tick_chk("dis_tick225", 1'b1);
      run_to(228); lit("dis_d0", 4'hF, 7'h7F, 1'b1);
      run_to(244); lit("dis_d2", 4'hF, 7'h7F, 1'b1);
      run_to(252); lit("dis_d3", 4'hF, 7'h7F, 1'b1);
      run_to(256);
      bus.digit_en = 4'hF;
      run_to(257); tick_chk("dis_tick257", 1'b1);

      // Asynchronous reset in the ON phase of digit1.
      run_to(268); lit("pre_reset_d1", 4'b1101, 7'b0111000, 1'b1);
      #2;
      reset_in = 1'b1;
      #1;
      lit("async_reset_pins", 4'hF, 7'h7F, 1'b1);
      tick_chk("async_reset_tick", 1'b0);
      repeat (2) @(negedge clk);
      lit("held_reset_pins", 4'hF, 7'h7F, 1'b1);

      // Restart with blink on digit0.
      bus.value    = 16'h1A2F;
      bus.dp       = 4'h0;
      bus.digit_en = 4'hF;
      bus.blink    = 4'b0001;
      bus.lz_blank = 1'b0;
      reset_in = 1'b0;
      t = 0;
      model_check();
      run_to(4);   lit("blink_f0_lit", 4'b1110, 7'b0111000, 1'b1);
      run_to(36);  lit("blink_f1_dark", 4'hF, 7'h7F, 1'b1);
      run_to(44);  lit("blink_f1_d1", 4'b1101, 7'b0010010, 1'b1);
      run_to(68);  lit("blink_f2_dark", 4'hF, 7'h7F, 1'b1);
      run_to(100); lit("blink_f3_lit", 4'b1110, 7'b0111000, 1'b1);
      run_to(132); lit("blink_f4_lit", 4'b1110, 7'b0111000, 1'b1);
      run_to(164); lit("blink_f5_dark", 4'hF, 7'h7F, 1'b1);
      run_to(196); lit("blink_f6_dark", 4'hF, 7'h7F, 1'b1);
      run_to(224);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
- Snapshots a 16-bit hex value once per frame and steps one digit per slot through a single internal hex_7seg decoder.
- Drives active-low anodes, segments and decimal point, with a blank guard interval between digits, per-digit enable, blink, and leading-zero suppression.
- Sits between the front-panel register and the board LED pins.

Parameters:
- PRESCALE, 12500, clk cycles per digit slot; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 64, guard cycles at the start of each slot with all anodes off; must be at least 1.
- BLINK_DIV, 32, frames per blink half-period; must be at least 1.

Ports:
- clk  in  1  system clock.
- reset_in  in  1  asynchronous, active-high reset.
- value  in  16  hex digits; digit0 = value[3:0] (rightmost), digit3 = value[15:12].
- dp  in  4  decimal point request per digit.
- digit_en  in  4  per-digit enable; 0 = digit dark.
- blink  in  4  per-digit blink enable.
- lz_blank  in  1  leading-zero suppression enable.
- an_n  out  4  anode drive, active-low; an_n[i] selects digit i.
- seg_n  out  7  segments {a,b,c,d,e,f,g}, active-low, taken directly from hex_7seg outputs.
- dp_n  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse after each snapshot.

Behaviour:
- Interface: one clock (clk); reset_in is asynchronous and active-high.
- Reset, asynchronous and taking effect immediately, including mid-slot:
  - state: digit=0, cnt=0, frame_cnt=0, blink_phase=0, snapshot registers=0.
  - outputs: an_n=4'hF, seg_n=7'h7F, dp_n=1, frame_tick=0.
- Counters:
  - cnt counts 0..PRESCALE-1 and then wraps.
  - On cnt wrap, digit advances 0→1→2→3→0.
  - The first cycle after reset release is digit0, cnt0.
- Snapshot:
  - At the clk edge ending the cycle with digit==0 && cnt==0, capture value, dp, digit_en, blink and lz_blank.
  - Inputs changing at any other time do not affect the current frame.
  - frame_tick=1 for exactly the cycle after that edge.
- Blink:
  - At each snapshot edge: if frame_cnt==BLINK_DIV-1, set frame_cnt=0 and toggle blink_phase; otherwise frame_cnt+1.
  - The new blink_phase applies to the frame just captured.
- Slot phases:
  - BLANK: cnt < BLANK_CYCLES.
  - ON: cnt ≥ BLANK_CYCLES.
- Digit i is visible when all hold:
  - snapshot digit_en[i]=1;
  - not (blink[i]=1 && blink_phase=1);
  - not leading-zero suppressed.
- Leading-zero suppression:
  - Digit i (i=3..1) is suppressed when lz_blank=1 and nibbles i..3 are all 0.
  - Digit0 is never suppressed.
- Suppressed digit with dp[i]=1: anode on, seg_n=7'h7F, dp_n=0.
- Output registers, one cycle latency from (digit,cnt):
  - BLANK, or ON with digit not visible (and not the dp case): an_n=4'hF, seg_n=7'h7F, dp_n=1.
  - ON with digit visible: an_n=~(1<<digit), seg_n=hex_7seg(nibble), dp_n=~dp[digit].
- Latency: digit0 first lights in cycle BLANK_CYCLES+1 after reset release and stays lit PRESCALE-BLANK_CYCLES cycles. Frame period = 4*PRESCALE.
- At most one anode is low in any cycle.
- Between two lit digits there are at least BLANK_CYCLES cycles with an_n=4'hF.

Test Plan (bench uses PRESCALE=8, BLANK_CYCLES=2, BLINK_DIV=2):
- Reset, then value=16'h1A2F, dp=0, digit_en=4'hF.
  - Cycles 3-8: an_n=4'b1110, seg_n=7'b0111000 (F).
  - Cycles 11-16: an_n=1101 showing 2.
  - Digit2 shows A, digit3 shows 1.
  - Exactly 2 all-off cycles between digits.
  - frame_tick high in cycles 1, 33, 65.
- value=16'h0050, lz_blank=1.
  - Digit3 and digit2 dark.
  - Digit1 shows 5, digit0 shows 0.
  - With dp[3]=1, digit3 shows an_n=0111, seg_n=7'h7F, dp_n=0.
- Change value to 16'hFFFF at cnt=4 of digit2.
  - The current frame still shows the old value.
  - The new value appears from the next frame's digit0.
- blink=4'b0001, digit_en=4'hF.
  - Digit0 lit in frames 0, 3, 4; dark in frames 1, 2, 5, 6.
  - Other digits are always lit.
- digit_en=4'b0000.
  - an_n stays 4'hF for a full frame.
  - frame_tick still pulses every 32 cycles.
- Assert reset_in mid-ON of digit1.
  - an_n=4'hF, seg_n=7'h7F and frame_tick=0 in the same cycle, before any clk edge.
  - After release the sequence restarts at digit0 with snapshots cleared.
